// File: rtl/mem_arbiter.sv
// Two-port (instruction fetch / data) arbiter in front of a fixed-latency unified memory.
// Define ARB_ROUND_ROBIN_EN to use round-robin instead of fixed data priority on simultaneous requests.
module mem_arbiter #(
    parameter int LAT = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        i_req,
    input  logic [15:0] i_addr,
    output logic        i_done,
    output logic [15:0] i_rdata,
    input  logic        d_req,
    input  logic        d_wr,
    input  logic [15:0] d_addr,
    input  logic [15:0] d_wdata,
    output logic        d_done,
    output logic [15:0] d_rdata,
    output logic        mem_en,
    output logic        mem_wr,
    output logic [15:0] mem_addr,
    output logic [15:0] mem_wdata,
    input  logic [15:0] mem_rdata,
    output logic        busy
);

    // Handshake: a request is sampled only in IDLE; there is no backpressure. Once granted, the
    // transaction always finishes with a one-cycle x_done, and that done cycle is itself IDLE.
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        BUSY_I = 2'd1,
        BUSY_D = 2'd2
    } state_t;

    localparam logic [3:0] CNT_INIT = 4'(LAT - 1);

    state_t     state;
    logic [3:0] cnt;
    logic       grant_d;

`ifdef ARB_ROUND_ROBIN_EN
    logic last_d;  // 1 when the most recent grant went to the data side

    always_comb begin
        grant_d = d_req && (!i_req || !last_d);
    end
`else
    always_comb begin
        grant_d = d_req;
    end
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            cnt       <= 4'd0;
            i_done    <= 1'b0;
            i_rdata   <= 16'd0;
            d_done    <= 1'b0;
            d_rdata   <= 16'd0;
            mem_en    <= 1'b0;
            mem_wr    <= 1'b0;
            mem_addr  <= 16'd0;
            mem_wdata <= 16'd0;
            busy      <= 1'b0;
`ifdef ARB_ROUND_ROBIN_EN
            last_d    <= 1'b0;
`endif
        end else begin
            mem_en <= 1'b0;
            i_done <= 1'b0;
            d_done <= 1'b0;
            case (state)
                IDLE: begin
                    if (i_req || d_req) begin
                        state     <= grant_d ? BUSY_D : BUSY_I;
                        cnt       <= CNT_INIT;
                        mem_en    <= 1'b1;
                        busy      <= 1'b1;
                        mem_addr  <= grant_d ? d_addr : i_addr;
                        mem_wr    <= grant_d && d_wr;
                        mem_wdata <= grant_d ? d_wdata : 16'd0;
`ifdef ARB_ROUND_ROBIN_EN
                        last_d    <= grant_d;
`endif
                    end
                end
                BUSY_I: begin
                    if (cnt == 4'd0) begin
                        state   <= IDLE;
                        busy    <= 1'b0;
                        i_done  <= 1'b1;
                        i_rdata <= mem_rdata;
                    end else begin
                        cnt <= cnt - 4'd1;
                    end
                end
                BUSY_D: begin
                    if (cnt == 4'd0) begin
                        state  <= IDLE;
                        busy   <= 1'b0;
                        d_done <= 1'b1;
                        // mem_wr still holds the qualifier of this access
                        if (!mem_wr) begin
                            d_rdata <= mem_rdata;
                        end
                    end else begin
                        cnt <= cnt - 4'd1;
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: vector table of single accesses plus
// hand-written sequences for contention, reset abort and request drop.
module tb_mem_arbiter;

    localparam int LAT = 4;

    typedef struct {
        logic        side_d;
        logic        wr;
        logic [15:0] addr;
        logic [15:0] wdata;
        logic [15:0] mem_word;
    } vec_t;

    logic        clk;
    logic        rst;
    logic        i_req;
    logic [15:0] i_addr;
    logic        i_done;
    logic [15:0] i_rdata;
    logic        d_req;
    logic        d_wr;
    logic [15:0] d_addr;
    logic [15:0] d_wdata;
    logic        d_done;
    logic [15:0] d_rdata;
    logic        mem_en;
    logic        mem_wr;
    logic [15:0] mem_addr;
    logic [15:0] mem_wdata;
    logic [15:0] mem_rdata;
    logic        busy;

    // {side_d, wr, read word}
    logic [17:0] exp_q[$];
    logic [15:0] model_i;
    logic [15:0] model_d;
    logic        prev_done;
    logic        prev_mem_en;
    int          errors;
    int          checks;

    mem_arbiter #(.LAT(LAT)) dut (
        .clk       (clk),
        .rst       (rst),
        .i_req     (i_req),
        .i_addr    (i_addr),
        .i_done    (i_done),
        .i_rdata   (i_rdata),
        .d_req     (d_req),
        .d_wr      (d_wr),
        .d_addr    (d_addr),
        .d_wdata   (d_wdata),
        .d_done    (d_done),
        .d_rdata   (d_rdata),
        .mem_en    (mem_en),
        .mem_wr    (mem_wr),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata),
        .busy      (busy)
    );

    // clock / reset block
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // scoreboard step, run at every sampling point
    task automatic monitor_step();
        logic [17:0] e;
        if (rst) begin
            model_i     = 16'd0;
            model_d     = 16'd0;
            prev_done   = 1'b0;
            prev_mem_en = 1'b0;
        end else begin
            if (mem_en) chk("mem_en_width", {31'd0, prev_mem_en}, 32'd0);
            if (i_done || d_done) begin
                chk("done_width", {31'd0, prev_done}, 32'd0);
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_done: got i_done=%b d_done=%b expected none", i_done, d_done);
                end else begin
                    e = exp_q.pop_front();
                    chk("done_side", {30'd0, i_done, d_done}, e[17] ? 32'd1 : 32'd2);
                    if (e[17]) begin
                        if (!e[16]) model_d = e[15:0];
                    end else begin
                        model_i = e[15:0];
                    end
                    chk("i_rdata", {16'd0, i_rdata}, {16'd0, model_i});
                    chk("d_rdata", {16'd0, d_rdata}, {16'd0, model_d});
                end
            end
            prev_done   = i_done | d_done;
            prev_mem_en = mem_en;
        end
    endtask

    task automatic tick();
        @(negedge clk);
        monitor_step();
    endtask

    task automatic wait_done(output int k);
        k = -1;
        for (int n = 1; n <= 40; n++) begin
            tick();
            if (i_done || d_done) begin
                k = n;
                break;
            end
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_busy"},      {31'd0, busy},      32'd0);
        chk({tag, "_mem_en"},    {31'd0, mem_en},    32'd0);
        chk({tag, "_mem_wr"},    {31'd0, mem_wr},    32'd0);
        chk({tag, "_mem_addr"},  {16'd0, mem_addr},  32'd0);
        chk({tag, "_mem_wdata"}, {16'd0, mem_wdata}, 32'd0);
        chk({tag, "_i_done"},    {31'd0, i_done},    32'd0);
        chk({tag, "_d_done"},    {31'd0, d_done},    32'd0);
        chk({tag, "_i_rdata"},   {16'd0, i_rdata},   32'd0);
        chk({tag, "_d_rdata"},   {16'd0, d_rdata},   32'd0);
    endtask

    // driver: one isolated access from IDLE
    task automatic do_single(input vec_t v);
        int k;
        tick();
        mem_rdata = v.mem_word;
        if (v.side_d) begin
            d_req = 1'b1; d_wr = v.wr; d_addr = v.addr; d_wdata = v.wdata;
        end else begin
            i_req = 1'b1; i_addr = v.addr;
        end
        exp_q.push_back({v.side_d, v.side_d & v.wr, v.mem_word});
        tick();
        i_req = 1'b0;
        d_req = 1'b0;
        chk("grant_mem_en",    {31'd0, mem_en},    32'd1);
        chk("grant_mem_addr",  {16'd0, mem_addr},  {16'd0, v.addr});
        chk("grant_mem_wr",    {31'd0, mem_wr},    {31'd0, v.side_d & v.wr});
        chk("grant_mem_wdata", {16'd0, mem_wdata}, v.side_d ? {16'd0, v.wdata} : 32'd0);
        chk("grant_busy",      {31'd0, busy},      32'd1);
        wait_done(k);
        chk("done_latency", k, LAT);
        chk("done_cycle_busy", {31'd0, busy}, 32'd0);
    endtask

    initial begin
        vec_t vecs[7];
        int   k;
        logic seen;

        errors = 0; checks = 0;
        model_i = 16'd0; model_d = 16'd0; prev_done = 1'b0; prev_mem_en = 1'b0;
        rst = 1'b1; i_req = 1'b1; i_addr = 16'h0011; d_req = 1'b0; d_wr = 1'b0;
        d_addr = 16'd0; d_wdata = 16'd0; mem_rdata = 16'd0;

        vecs[0] = '{1'b0, 1'b0, 16'h0010, 16'h0000, 16'hBEEF};
        vecs[1] = '{1'b1, 1'b1, 16'h0200, 16'h1234, 16'hDEAD};
        vecs[2] = '{1'b1, 1'b0, 16'h0300, 16'h0000, 16'h5A5A};
        vecs[3] = '{1'b1, 1'b1, 16'h0400, 16'hFFFF, 16'h0BAD};
        vecs[4] = '{1'b1, 1'b0, 16'($urandom_range(0, 65535)), 16'h0000, 16'($urandom_range(1, 65535))};
        vecs[5] = '{1'b0, 1'b0, 16'($urandom_range(0, 65535)), 16'h0000, 16'($urandom_range(1, 65535))};
        vecs[6] = '{1'b0, 1'b0, 16'hFFFF, 16'h0000, 16'h0001};

        // reset with a request already pending: nothing may be granted
        repeat (3) tick();
        check_reset_outputs("reset");
        rst = 1'b0;
        i_req = 1'b0;

        for (int v = 0; v < 7; v++) do_single(vecs[v]);

        // both sides held high for three transactions
        tick();
        mem_rdata = 16'h7777; d_wr = 1'b0; d_addr = 16'h0600; i_addr = 16'h0060;
        i_req = 1'b1; d_req = 1'b1;
        exp_q.push_back({1'b1, 1'b0, 16'h7777});
`ifdef ARB_ROUND_ROBIN_EN
        exp_q.push_back({1'b0, 1'b0, 16'h7777});
`else
        exp_q.push_back({1'b1, 1'b0, 16'h7777});
`endif
        exp_q.push_back({1'b1, 1'b0, 16'h7777});
        for (int n = 0; n < 3; n++) begin
            wait_done(k);
            chk("contend_gap", k, LAT + 1);
        end
        i_req = 1'b0; d_req = 1'b0;
        tick();
        chk("contend_no_extra_grant", {31'd0, mem_en}, 32'd0);

        // reset two cycles into BUSY_I aborts the fetch
        tick();
        i_req = 1'b1; i_addr = 16'h0080; mem_rdata = 16'hCAFE;
        tick();
        i_req = 1'b0;
        tick();
        #2 rst = 1'b1;
        #1 check_reset_outputs("abort");
        tick();
        rst = 1'b0;
        seen = 1'b0;
        repeat (LAT + 2) begin
            tick();
            seen = seen | i_done | d_done;
        end
        chk("abort_no_done", {31'd0, seen}, 32'd0);
        do_single('{1'b0, 1'b0, 16'h0090, 16'h0000, 16'h4321});

        // fetch request dropped after grant, data request raised while busy
        tick();
        i_req = 1'b1; i_addr = 16'h0040; mem_rdata = 16'h2222;
        exp_q.push_back({1'b0, 1'b0, 16'h2222});
        exp_q.push_back({1'b1, 1'b0, 16'h3333});
        tick();
        i_req = 1'b0;
        tick();
        d_req = 1'b1; d_wr = 1'b0; d_addr = 16'h0500;
        wait_done(k);
        chk("drop_i_latency", k, LAT - 1);
        mem_rdata = 16'h3333;
        tick();
        chk("late_d_mem_en",   {31'd0, mem_en},   32'd1);
        chk("late_d_mem_addr", {16'd0, mem_addr}, 32'h0000_0500);
        chk("late_d_busy",     {31'd0, busy},     32'd1);
        d_req = 1'b0;
        wait_done(k);
        chk("late_d_latency", k, LAT);

        repeat (3) tick();
        chk("scoreboard_empty", exp_q.size(), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
